// File: rtl/sky_alu_issue.sv
// sky_alu_issue
// Issue/collect front-end for the execute-stage ALU. It accepts tagged requests
// on a valid/ready port and drives the ALU operand and operation inputs for the
// accepted request. It then collects the registered ALU result, zero flag and
// sampled overflow into a 2-entry response FIFO, which drains on a valid/ready port.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (fire = req_valid && req_ready)
//   req_a, req_b, req_op       operands and ALU op (0..10 legal, 11..15 illegal)
//   req_tag                    tag passed through to the response
//   alu_operand_a/b, alu_operation   ALU drive (all zero when not firing)
//   alu_result, alu_zero       ALU registered result and its zero flag
//   alu_overflow               ALU combinational overflow on current operands
//   rsp_valid/rsp_ready        response handshake (pop = rsp_valid && rsp_ready)
//   rsp_result, rsp_zero, rsp_overflow, rsp_illegal, rsp_tag   FIFO head
//   retired_count              popped responses, wraps modulo 2^CNT_W
module sky_alu_issue #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [3:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_operand_a,
  output logic [31:0]      alu_operand_b,
  output logic [3:0]       alu_operation,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LAST = 4'd10;

  typedef struct packed {
    logic [31:0]      result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  // Issue-side state: one op can be in flight inside the ALU.
  logic             infl_q;
  logic [TAG_W-1:0] tag_q;
  logic             ill_q;
  logic             ovf_q;

  // Response FIFO.
  rsp_t             mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;

  logic             fire;
  logic             pop;
  logic             push;
  logic [2:0]       pending;
  rsp_t             push_data;
  rsp_t             head;

  assign rsp_valid = (occ_q != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = infl_q;

  // Entries that will still hold a FIFO slot after this cycle: queued ones,
  // plus the result landing from the ALU, minus the one being popped. Accepting
  // only while this is at most 1 leaves a slot free for the new request's
  // result, so a push never meets a full FIFO.
  assign pending   = 3'(occ_q) + 3'(infl_q) - 3'(pop);
  assign req_ready = (pending <= 3'd1);
  assign fire      = req_valid && req_ready;

  // The ALU sees ADD 0,0 whenever nothing is being issued.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned; otherwise synthesis infers a latch.
    alu_operand_a = '0;
    alu_operand_b = '0;
    alu_operation = OP_ADD;
    if (fire) begin
      alu_operand_a = req_a;
      alu_operand_b = req_b;
      alu_operation = req_op;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      infl_q <= 1'b0;
      tag_q  <= '0;
      ill_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      infl_q <= fire;
      if (fire) begin
        tag_q <= req_tag;
        ill_q <= (req_op > OP_LAST);
        // The ALU overflow flag only reflects the operands while they are
        // applied, so it is captured in the issue cycle, not with the result.
        ovf_q <= alu_overflow && ((req_op == OP_ADD) || (req_op == OP_SUB));
      end
    end
  end

  assign push_data = '{result:   alu_result,
                       zero:     alu_zero,
                       overflow: ovf_q,
                       illegal:  ill_q,
                       tag:      tag_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the two storage entries are reset because the head drives the
      // response data outputs directly and those must read zero after reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign rsp_result   = head.result;
  assign rsp_zero     = head.zero;
  assign rsp_overflow = head.overflow;
  assign rsp_illegal  = head.illegal;
  assign rsp_tag      = head.tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
    end else if (pop) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule
